// File: rtl/pipe_addsub_pkg.sv
// Shared types and operand decode for the pipelined add/subtract unit.
package pipe_addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } addsub_op_t;

    // Operand conditioning applied when a beat is accepted.
    typedef struct packed {
        logic b_inv;  // feed ~B into the adder (subtract forms)
        logic cin;    // carry into slice 0
    } op_ctl_t;

    // Subtract is A + ~B + 1; SBC replaces the +1 with the caller's carry,
    // so CarryIn=1 means "no borrow pending".
    function automatic op_ctl_t decode_op(input addsub_op_t op, input logic carry_in);
        op_ctl_t ctl;
        ctl.b_inv = (op == OP_SUB) || (op == OP_SBC);
        case (op)
            OP_ADD:  ctl.cin = 1'b0;
            OP_SUB:  ctl.cin = 1'b1;
            default: ctl.cin = carry_in;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice.
module addsub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] A,
    input  logic [SLICE-1:0] B,
    input  logic             Cin,
    output logic [SLICE-1:0] S,
    output logic             Cout,
    output logic             C_msb
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   gx;
    logic [SLICE:0]   c;
    logic             term;

    assign g  = A & B;
    assign p  = A ^ B;
    // gx[0] is the incoming carry treated as a generate below bit 0.
    assign gx = {g, Cin};

    // Each carry is a flat sum of products: some bit j generates and every
    // bit from j up to i propagates. No carry depends on a lower carry.
    always_comb begin
        c    = '0;
        term = 1'b0;
        c[0] = Cin;
        for (int i = 0; i < SLICE; i++) begin
            for (int j = 0; j <= i + 1; j++) begin
                term = gx[j];
                for (int m = j; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign S     = p ^ c[SLICE-1:0];
    assign Cout  = c[SLICE];
    assign C_msb = c[SLICE-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: one lookahead slice per stage, carry registered
// between stages, valid/ready handshake with bubble collapse.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             MasterClock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       Op,
    input  logic             CarryIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero
);

    localparam int NSTAGE = WIDTH / SLICE;

    // Stage registers. a/b carry the not-yet-consumed upper slices forward;
    // c_q[k] is the carry into slice k+1 (CarryOut for the last stage).
    logic [NSTAGE-1:0] v_q, v_d;
    logic [NSTAGE-1:0] c_q, c_d;
    logic [WIDTH-1:0]  sum_q [NSTAGE];
    logic [WIDTH-1:0]  sum_d [NSTAGE];
    logic [WIDTH-1:0]  a_q   [NSTAGE];
    logic [WIDTH-1:0]  a_d   [NSTAGE];
    logic [WIDTH-1:0]  b_q   [NSTAGE];
    logic [WIDTH-1:0]  b_d   [NSTAGE];
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;

    // What each stage would load: ports for stage 0, previous stage otherwise.
    logic [NSTAGE-1:0] src_v;
    logic [NSTAGE-1:0] src_c;
    logic [WIDTH-1:0]  src_sum [NSTAGE];
    logic [WIDTH-1:0]  src_a   [NSTAGE];
    logic [WIDTH-1:0]  src_b   [NSTAGE];

    logic [SLICE-1:0]  slice_s    [NSTAGE];
    logic [NSTAGE-1:0] slice_cout;
    logic              slice_cmsb [NSTAGE];

    op_ctl_t           ctl;
    logic [WIDTH-1:0]  b_eff;
    logic              in_fire;
    logic [NSTAGE-1:0] adv;

    assign ctl     = decode_op(addsub_op_t'(Op), CarryIn);
    assign b_eff   = ctl.b_inv ? ~B : B;
    assign InReady = adv[0] & ~Reset;
    assign in_fire = InValid & InReady;

    // Advance chain: a stage may load if it is empty or its content moves on.
    always_comb begin
        adv           = '0;
        adv[NSTAGE-1] = ~v_q[NSTAGE-1] | OutReady;
        for (int k = NSTAGE - 2; k >= 0; k--) begin
            adv[k] = ~v_q[k] | adv[k+1];
        end
    end

    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign src_v[gi]   = in_fire;
            assign src_c[gi]   = ctl.cin;
            assign src_sum[gi] = '0;
            assign src_a[gi]   = A;
            assign src_b[gi]   = b_eff;
        end else begin : g_body
            assign src_v[gi]   = v_q[gi-1];
            assign src_c[gi]   = c_q[gi-1];
            assign src_sum[gi] = sum_q[gi-1];
            assign src_a[gi]   = a_q[gi-1];
            assign src_b[gi]   = b_q[gi-1];
        end

        addsub_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .A     (src_a[gi][gi*SLICE +: SLICE]),
            .B     (src_b[gi][gi*SLICE +: SLICE]),
            .Cin   (src_c[gi]),
            .S     (slice_s[gi]),
            .Cout  (slice_cout[gi]),
            .C_msb (slice_cmsb[gi])
        );
    end

    // Next-state: advancing stages take upstream content plus their own slice.
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            v_d[k]   = v_q[k];
            c_d[k]   = c_q[k];
            sum_d[k] = sum_q[k];
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            if (adv[k]) begin
                v_d[k]                      = src_v[k];
                c_d[k]                      = slice_cout[k];
                sum_d[k]                    = src_sum[k];
                sum_d[k][k*SLICE +: SLICE]  = slice_s[k];
                a_d[k]                      = src_a[k];
                b_d[k]                      = src_b[k];
            end
        end
        zero_d = zero_q;
        ovf_d  = ovf_q;
        if (adv[NSTAGE-1]) begin
            zero_d = ~|sum_d[NSTAGE-1];
            ovf_d  = slice_cmsb[NSTAGE-1] ^ slice_cout[NSTAGE-1];
        end
    end

    // Stage register bank; reset discards everything in flight.
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            v_q    <= '0;
            c_q    <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int k = 0; k < NSTAGE; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            v_q    <= v_d;
            c_q    <= c_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
            for (int k = 0; k < NSTAGE; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

    assign OutValid = v_q[NSTAGE-1];
    assign Sum      = sum_q[NSTAGE-1];
    assign CarryOut = c_q[NSTAGE-1];
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed table, backpressure and reset
// sequences on a 16/4 instance, random traffic on 8/8 and 32/4 instances.
module tb_pipe_addsub;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] sum;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main 16/4 instance ----------------
    logic        rst_m, m_iv, m_ir, m_ci, m_ov, m_or, m_co, m_ovf, m_z;
    logic [15:0] m_a, m_b, m_sum;
    logic [1:0]  m_op;

    pipe_addsub #(.WIDTH(16), .SLICE(4)) u_main (
        .MasterClock (clk),   .Reset    (rst_m),
        .InValid     (m_iv),  .InReady  (m_ir),
        .A           (m_a),   .B        (m_b),
        .Op          (m_op),  .CarryIn  (m_ci),
        .OutValid    (m_ov),  .OutReady (m_or),
        .Sum         (m_sum), .CarryOut (m_co),
        .Overflow    (m_ovf), .Zero     (m_z)
    );

    // ---------------- sweep instances (0: 8/8, 1: 32/4) ----------------
    logic        rst_s;
    logic        r_iv [2];
    logic        r_or [2];
    logic        r_ci [2];
    logic [1:0]  r_op [2];
    logic [31:0] r_a  [2];
    logic [31:0] r_b  [2];
    logic        r_ir [2];
    logic        r_ov [2];
    logic        r_co [2];
    logic        r_vf [2];
    logic        r_z  [2];
    logic [31:0] r_sum [2];
    logic [7:0]  s8_sum;
    logic [31:0] s32_sum;

    assign r_sum[0] = {24'h0, s8_sum};
    assign r_sum[1] = s32_sum;

    pipe_addsub #(.WIDTH(8), .SLICE(8)) u_w8 (
        .MasterClock (clk),          .Reset    (rst_s),
        .InValid     (r_iv[0]),      .InReady  (r_ir[0]),
        .A           (r_a[0][7:0]),  .B        (r_b[0][7:0]),
        .Op          (r_op[0]),      .CarryIn  (r_ci[0]),
        .OutValid    (r_ov[0]),      .OutReady (r_or[0]),
        .Sum         (s8_sum),       .CarryOut (r_co[0]),
        .Overflow    (r_vf[0]),      .Zero     (r_z[0])
    );

    pipe_addsub #(.WIDTH(32), .SLICE(4)) u_w32 (
        .MasterClock (clk),          .Reset    (rst_s),
        .InValid     (r_iv[1]),      .InReady  (r_ir[1]),
        .A           (r_a[1]),       .B        (r_b[1]),
        .Op          (r_op[1]),      .CarryIn  (r_ci[1]),
        .OutValid    (r_ov[1]),      .OutReady (r_or[1]),
        .Sum         (s32_sum),      .CarryOut (r_co[1]),
        .Overflow    (r_vf[1]),      .Zero     (r_z[1])
    );

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t ref_model(input int w, input logic [1:0] op,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic ci);
        res_t   r;
        longint mask, ua, ub, full, sa, sb, sres, lim, cval;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        lim  = longint'(1) << (w - 1);
        sa   = (ua >= lim) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= lim) ? ub - (longint'(1) << w) : ub;
        case (op)
            2'd0:    cval = 0;
            2'd1:    cval = 1;
            default: cval = ci ? 1 : 0;
        endcase
        if (op[0] == 1'b0) begin
            full   = ua + ub + cval;
            sres   = sa + sb + cval;
            r.cout = (full > mask);
        end else begin
            full   = ua - ub - (1 - cval);
            sres   = sa - sb - (1 - cval);
            r.cout = (full >= 0);
        end
        r.sum  = 32'(full & mask);
        r.ovf  = (sres >= lim) || (sres < -lim);
        r.zero = ((full & mask) == 0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Random traffic with random valid/ready against a scoreboard queue.
    task automatic run_random(input int idx, input int w, input int nst, input int nops);
        res_t q[$];
        res_t e, got;
        int   lat, acc, cyc;
        r_iv[idx] = 1'b0; r_or[idx] = 1'b1; r_op[idx] = 2'd0; r_ci[idx] = 1'b0;
        r_a[idx]  = 32'd0; r_b[idx] = 32'd0;
        @(negedge clk);
        r_iv[idx] = 1'b1; r_a[idx] = 32'd3; r_b[idx] = 32'd4;
        @(negedge clk);
        r_iv[idx] = 1'b0;
        lat = 1;
        while (!r_ov[idx] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency_w%0d", w), 64'(lat), 64'(nst));
        chk($sformatf("first_sum_w%0d", w), 64'(r_sum[idx]), 64'd7);
        $display("w=%0d latency beat 3+4 -> sum=%0d after %0d edges", w, r_sum[idx], lat);
        acc = 0;
        cyc = 0;
        while (acc < nops && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            r_iv[idx] = ($urandom_range(0, 9) < 8);
            r_or[idx] = ($urandom_range(0, 9) < 7);
            r_a[idx]  = $urandom;
            r_b[idx]  = $urandom;
            r_op[idx] = 2'($urandom_range(0, 3));
            r_ci[idx] = 1'($urandom_range(0, 1));
            #1;
            if (r_ov[idx] && r_or[idx]) begin
                if (q.size() == 0) begin
                    chk($sformatf("spurious_w%0d", w), 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    got.sum = r_sum[idx]; got.cout = r_co[idx];
                    got.ovf = r_vf[idx];  got.zero = r_z[idx];
                    chk($sformatf("rand_w%0d", w), 64'(got), 64'(e));
                end
            end
            if (r_iv[idx] && r_ir[idx]) begin
                q.push_back(ref_model(w, r_op[idx], r_a[idx], r_b[idx], r_ci[idx]));
                acc++;
            end
        end
        chk($sformatf("accepted_w%0d", w), 64'(acc), 64'(nops));
        cyc = 0;
        while (q.size() > 0 && cyc < 100) begin
            @(negedge clk);
            r_iv[idx] = 1'b0;
            r_or[idx] = 1'b1;
            #1;
            if (r_ov[idx]) begin
                e = q.pop_front();
                got.sum = r_sum[idx]; got.cout = r_co[idx];
                got.ovf = r_vf[idx];  got.zero = r_z[idx];
                chk($sformatf("drain_w%0d", w), 64'(got), 64'(e));
            end
            cyc++;
        end
        chk($sformatf("drained_w%0d", w), 64'(q.size()), 64'd0);
        $display("w=%0d random run: %0d beats accepted", w, acc);
    endtask

    vec_t        vecs [10];
    logic [15:0] bp_a [6];
    logic [15:0] bp_b [6];
    logic [1:0]  bp_op [6];
    logic        bp_ci [6];
    res_t        bp_exp [6];

    initial begin
        int   lat, idx, nout, last_cyc, cyc, stale;
        logic acc;
        res_t got;

        vecs[0] = '{2'd0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2'd2, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{2'd3, 16'h0005, 16'h0003, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'd1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{2'd0, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{2'd1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{2'd2, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{2'd3, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};

        rst_m = 1'b1; rst_s = 1'b1;
        m_iv = 1'b0; m_or = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_ci = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_iv[i] = 1'b0; r_or[i] = 1'b0; r_ci[i] = 1'b0; r_op[i] = '0;
            r_a[i] = '0; r_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({m_ov, m_ir, m_sum, m_co, m_ovf, m_z}), 64'd0);
        @(negedge clk);
        rst_m = 1'b0; rst_s = 1'b0;
        #1;
        chk("ready_after_reset", 64'(m_ir), 64'd1);

        // Directed table, one beat at a time with OutReady held high.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            m_iv = 1'b1; m_or = 1'b1;
            m_op = vecs[i].op; m_a = vecs[i].a; m_b = vecs[i].b; m_ci = vecs[i].ci;
            @(negedge clk);
            m_iv = 1'b0;
            lat = 1;
            while (!m_ov && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_result", i), 64'({m_sum, m_co, m_ovf, m_z}),
                64'({vecs[i].sum, vecs[i].co, vecs[i].ov, vecs[i].z}));
            $display("vec %0d op=%0d a=%h b=%h ci=%b -> sum=%h c=%b v=%b z=%b lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, m_sum, m_co, m_ovf, m_z, lat);
        end

        // Backpressure: six beats offered against a stalled consumer.
        for (int i = 0; i < 6; i++) begin
            bp_a[i]  = 16'($urandom);
            bp_b[i]  = 16'($urandom);
            bp_op[i] = 2'($urandom_range(0, 3));
            bp_ci[i] = 1'($urandom_range(0, 1));
            bp_exp[i] = ref_model(16, bp_op[i], 32'(bp_a[i]), 32'(bp_b[i]), bp_ci[i]);
        end
        @(negedge clk);
        m_or = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            m_iv = 1'b1; m_a = bp_a[idx]; m_b = bp_b[idx]; m_op = bp_op[idx]; m_ci = bp_ci[idx];
            #1;
            acc = m_iv && m_ir;
            if (m_ov) chk($sformatf("stall_head_c%0d", c), 64'(m_sum), 64'(bp_exp[0].sum[15:0]));
            @(negedge clk);
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd4);
        m_iv = 1'b1; m_a = bp_a[idx]; m_b = bp_b[idx]; m_op = bp_op[idx]; m_ci = bp_ci[idx];
        #1;
        chk("bp_inready_full", 64'(m_ir), 64'd0);
        chk("bp_head_held", 64'({m_ov, m_sum}), 64'({1'b1, bp_exp[0].sum[15:0]}));
        m_or = 1'b1;
        nout = 0; last_cyc = 0; cyc = 0;
        while (nout < 6 && cyc < 30) begin
            if (idx < 6) begin
                m_iv = 1'b1; m_a = bp_a[idx]; m_b = bp_b[idx]; m_op = bp_op[idx]; m_ci = bp_ci[idx];
            end else begin
                m_iv = 1'b0;
            end
            #1;
            acc = m_iv && m_ir;
            if (m_ov) begin
                got.sum = 32'(m_sum); got.cout = m_co; got.ovf = m_ovf; got.zero = m_z;
                chk($sformatf("bp_out%0d", nout), 64'(got), 64'(bp_exp[nout]));
                if (nout > 0) chk($sformatf("bp_gap%0d", nout), 64'(cyc - last_cyc), 64'd1);
                $display("bp out %0d sum=%h c=%b v=%b z=%b cycle=%0d", nout, m_sum, m_co, m_ovf, m_z, cyc);
                last_cyc = cyc;
                nout++;
            end
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        chk("bp_out_count", 64'(nout), 64'd6);
        m_iv = 1'b0;

        // Reset with three beats in flight.
        @(negedge clk);
        m_or = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_iv = 1'b1; m_a = 16'(c + 1); m_b = 16'h0100; m_op = 2'd0;
            @(negedge clk);
        end
        m_iv = 1'b0;
        rst_m = 1'b1;
        @(negedge clk);
        #1;
        chk("midreset_outputs", 64'({m_ov, m_ir, m_sum, m_co, m_ovf, m_z}), 64'd0);
        rst_m = 1'b0;
        #1;
        chk("midreset_ready", 64'(m_ir), 64'd1);
        m_or = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (m_ov) stale++;
        end
        chk("midreset_no_stale", 64'(stale), 64'd0);
        $display("reset mid-flight: stale results seen=%0d", stale);

        // Width sweep with random traffic on both extra instances in parallel.
        fork
            run_random(0, 8, 1, 10000);
            run_random(1, 32, 8, 10000);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined add/subtract unit built from SLICE-bit carry-lookahead slices, one slice per pipeline stage.
- Carry ripples between stages through registers, so WIDTH is bounded only by latency, not by the combinational carry path.
- Adds subtract and carry-chained modes, status flags and a valid/ready handshake with bubble collapse.
- Serves as the shared arithmetic block for blitter/DSP address and data paths.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits per stage; 1 <= SLICE <= WIDTH.
- NSTAGE, WIDTH/SLICE, derived (localparam); pipeline depth and latency.

Ports:
- MasterClock  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  operand beat present.
- InReady  out  1  block accepts a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- CarryIn  in  1  carry for ADC/SBC; ignored for ADD/SUB.
- OutValid  out  1  result present.
- OutReady  in  1  consumer takes result.
- Sum  out  WIDTH  result.
- CarryOut  out  1  carry out of MSB; for SUB/SBC, 1 means no borrow.
- Overflow  out  1  two's-complement overflow.
- Zero  out  1  Sum == 0.

Behaviour:
- Clock and reset: one clock (MasterClock); Reset is synchronous and active-high.
- Operand conditioning at acceptance:
  - Beff = B for ADD/ADC, ~B for SUB/SBC.
  - Cin = 0 for ADD, 1 for SUB, CarryIn for ADC/SBC.
- Stage k register (k = 0..NSTAGE-1) holds:
  - Vk: valid.
  - Slices 0..k of the sum.
  - Carry into slice k+1.
  - Unconsumed upper slices of A and Beff.
  - Carry into the MSB (last stage only).
- Stage 0 loads from the ports and computes slice 0. Stage k loads from stage k-1 and computes slice k with that stage's registered carry.
- Outputs are driven directly from stage NSTAGE-1: OutValid = V[NSTAGE-1]; Sum, CarryOut, Overflow and Zero are registered.
- Overflow = carry into MSB XOR CarryOut. Zero = ~|Sum.
- Handshake and bubble collapse:
  - adv[NSTAGE-1] = ~V[NSTAGE-1] | OutReady.
  - adv[k] = ~V[k] | adv[k+1].
  - InReady = adv[0] & ~Reset.
  - A stage with adv high loads its upstream content; the upstream V goes to 0 if nothing replaces it.
- Acceptance is InValid & InReady. Throughput is 1 beat/cycle when OutReady is held high.
- Latency: a beat accepted at edge t appears with OutValid=1 after edge t+NSTAGE-1, i.e. NSTAGE register stages, assuming no stall.
- Full: all NSTAGE stages valid and OutReady=0, so InReady=0. Capacity is NSTAGE beats.
- Simultaneous OutReady & InValid when full: the output is consumed and a new beat is accepted in the same cycle; no loss or duplication.
- Results leave strictly in acceptance order.
- Stall: while OutValid=1 and OutReady=0, Sum and all flags hold stable.
- Reset value of every output: OutValid=0, InReady=0, Sum=0, CarryOut=0, Overflow=0, Zero=0. All stage registers are cleared.
- Reset mid-operation: in-flight beats are discarded, with no partial result emitted. InReady returns to 1 in the first cycle after Reset deasserts.
- Arithmetic wraps modulo 2^WIDTH. No saturation.
- NSTAGE=1 degenerates to a single registered adder with latency 1.

Decomposition:
- Package pipe_addsub_pkg holds:
  - typedef enum addsub_op_t {OP_ADD, OP_SUB, OP_ADC, OP_SBC} (2 bits);
  - the Cin/B-invert decode function.
- Sub-module addsub_slice (combinational, parameter SLICE): inputs A, B, Cin; outputs S, Cout, C_msb (carry into its top bit). It uses generate/propagate lookahead within the slice.
- pipe_addsub instantiates NSTAGE addsub_slice copies plus the stage registers and the handshake chain.

Test Plan:
- WIDTH=16 ADD, A=0x1234, B=0x0FCD, OutReady=1 -> after 4 cycles: Sum=0x2201, CarryOut=0, Overflow=0, Zero=0.
- SUB 0x0000-0x0001 -> Sum=0xFFFF, CarryOut=0 (borrow), Overflow=0.
  - Also ADD 0x7FFF+0x0001 -> Sum=0x8000, Overflow=1, CarryOut=0.
- ADC 0xFFFF+0x0000 with CarryIn=1 -> Sum=0x0000, CarryOut=1, Zero=1.
  - Also SBC 0x0005-0x0003 with CarryIn=0 -> Sum=0x0001, CarryOut=1.
- Backpressure: OutReady=0, 6 back-to-back beats -> exactly 4 accepted, then InReady=0.
  - Raise OutReady -> all 6 results emerge in order, one per cycle, and the Sum of the stalled head is held stable.
- Reset asserted with 3 beats in flight -> next cycle OutValid=0, all outputs 0; no stale result ever emerges.
  - InReady=1 in the first cycle after deassert.
- Parameter sweep WIDTH=8/SLICE=8 and WIDTH=32/SLICE=4 with 10k random ops -> bit-exact against a reference model, with latencies 1 and 8 respectively.
